// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver states
// and helpers used by both the tick generator and the receiver core.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } rx_state_e;

  // Phase increment of a 24-bit accumulator, rounded to nearest.
  function automatic int tick_incr(input int clk_hz, input int baud, input int os);
    longint num;
    num = longint'(baud) * longint'(os) * 64'sd16777216;
    return int'((num + longint'(clk_hz) / 64'sd2) / longint'(clk_hz));
  endfunction

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/oversample_tick_gen.sv
// Fractional baud-rate generator: a 24-bit phase accumulator whose carry out
// is a one-clock tick at BAUD*OVERSAMPLE on average.
module oversample_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 66000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam logic [24:0] INCR = 25'(tick_incr(CLK_HZ, BAUD, OVERSAMPLE));

  logic [23:0] acc_q, acc_d;
  logic        tick_q, tick_d;

  always_comb begin
    {tick_d, acc_d} = {1'b0, acc_q} + INCR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= 24'd0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised RS-232 receiver: oversampled majority-filtered line, framing
// FSM with parity/stop/break checks, FWFT output FIFO and idle/EOP tracking.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 66000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_BITS  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_break,
  output logic                          rx_overrun,
  output logic                          rx_idle,
  output logic                          rx_eop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int BW      = $clog2(DATA_BITS);
  localparam int EW      = DATA_BITS + 2;
  localparam int GAP_MAX = IDLE_BITS * OVERSAMPLE;
  localparam int GW      = $clog2(GAP_MAX + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic [GW-1:0] G_MAX  = GW'(GAP_MAX);
  localparam logic          ODD    = 1'(PARITY == PAR_ODD);

  if ((OVERSAMPLE < 8) || ((OVERSAMPLE & (OVERSAMPLE - 1)) != 0)) begin : g_bad_os
    $error("OVERSAMPLE must be a power of 2 and at least 8");
  end
  if (CLK_HZ < BAUD * OVERSAMPLE) begin : g_bad_clk
    $error("CLK_HZ must be at least BAUD*OVERSAMPLE");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2)) begin : g_bad_fmt
    $error("DATA_BITS must be 5..9 and PARITY 0..2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic tick;

  oversample_tick_gen #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick_o(tick)
  );

  logic [1:0] sync_q, sync_d;
  logic [2:0] samp_q, samp_d;
  logic       bit_f_q, bit_f_d;

  always_comb begin
    sync_d  = {sync_q[0], rxd};
    samp_d  = samp_q;
    bit_f_d = bit_f_q;
    if (tick) begin
      samp_d  = {samp_q[1:0], sync_q[1]};
      bit_f_d = maj3(samp_d);
    end else begin
      samp_d  = samp_q;
    end
  end

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 any_q, any_d, xor_q, xor_d, pbit_q, pbit_d, perr_q, perr_d;
  logic                 push_q, push_d, brk_q, brk_d;
  logic [EW-1:0]        pdata_q, pdata_d;
  logic                 mid;

  assign mid = tick && (tcnt_q == T_MID);

  // Framing FSM; every state acts at mid-bit except IDLE/WAIT_HIGH, which react per tick.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    any_d   = any_q;
    xor_d   = xor_q;
    pbit_d  = pbit_q;
    perr_d  = perr_q;
    pdata_d = pdata_q;
    push_d  = 1'b0;
    brk_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick && !bit_f_q) begin
          state_d = S_START;
          tcnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (mid) begin
          if (bit_f_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bcnt_d  = '0;
            any_d   = 1'b0;
            xor_d   = 1'b0;
            pbit_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (mid) begin
          shreg_d = {bit_f_q, shreg_q[DATA_BITS-1:1]};
          any_d   = any_q | bit_f_q;
          xor_d   = xor_q ^ bit_f_q;
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == B_LAST) begin
            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (mid) begin
          pbit_d  = bit_f_q;
          perr_d  = ((xor_q ^ bit_f_q) != ODD);
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (mid) begin
          if (bit_f_q) begin
            push_d  = 1'b1;
            pdata_d = {perr_q, 1'b0, shreg_q};
            state_d = S_IDLE;
          end else if (!any_q && !pbit_q) begin
            brk_d   = 1'b1;
            state_d = S_WAIT_HIGH;
          end else begin
            push_d  = 1'b1;
            pdata_d = {perr_q, 1'b1, shreg_q};
            state_d = S_WAIT_HIGH;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        if (tick && bit_f_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          empty, full, pop, wr_en, ovr_d, ovr_q;
  logic [GW-1:0] gap_q, gap_d;
  logic          pend_q, pend_d, eop_q, eop_d;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  always_comb begin
    empty  = (wr_q == rd_q);
    full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop    = !empty && rx_ready;
    wr_en  = push_q && (!full || pop);
    ovr_d  = push_q && full && !pop;
    wr_d   = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d   = pop ? rd_q + 1'b1 : rd_q;
    if (state_q != S_IDLE) begin
      gap_d = '0;
    end else if (tick && (gap_q != G_MAX)) begin
      gap_d = gap_q + 1'b1;
    end else begin
      gap_d = gap_q;
    end
    eop_d  = pend_q && (gap_d == G_MAX) && (gap_q != G_MAX);
    pend_d = wr_en | (pend_q & !eop_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      samp_q  <= 3'b111;
      bit_f_q <= 1'b1;
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      any_q   <= 1'b0;
      xor_q   <= 1'b0;
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
      push_q  <= 1'b0;
      brk_q   <= 1'b0;
      pdata_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ovr_q   <= 1'b0;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      samp_q  <= samp_d;
      bit_f_q <= bit_f_d;
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      any_q   <= any_d;
      xor_q   <= xor_d;
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
      push_q  <= push_d;
      brk_q   <= brk_d;
      pdata_q <= pdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovr_q   <= ovr_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      eop_q   <= eop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_q[AW-1:0]] <= pdata_q;
    end
  end

  assign {rx_parity_err, rx_frame_err, rx_data} = mem_q[rd_q[AW-1:0]];
  assign rx_valid   = !empty;
  assign fifo_count = wr_q - rd_q;
  assign rx_break   = brk_q;
  assign rx_overrun = ovr_q;
  assign rx_idle    = (gap_q == G_MAX);
  assign rx_eop     = eop_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 and an 8E1 instance, expected
// entries queued as frames are driven and compared when popped.
module tb_uart_rx_param;

  localparam int CLK_HZ = 64000000;
  localparam int BAUD   = 1000000;
  localparam int OS     = 16;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int BIT    = 640;  // 16 ticks of 4 clocks at 10 time units per clock

  logic clk = 1'b0;
  logic rst_n;
  logic rxd_n, ready_n, rxd_e, ready_e;
  logic [7:0] data_n, data_e;
  logic perr_n, ferr_n, valid_n, brk_n, ovr_n, idle_n, eop_n;
  logic perr_e, ferr_e, valid_e, brk_e, ovr_e, idle_e, eop_e;
  logic [CW-1:0] cnt_n, cnt_e;

  int n_tests = 0;
  int n_fail  = 0;
  int brk_cnt_n = 0, ovr_cnt_n = 0, eop_cnt_n = 0, brk_cnt_e = 0;
  int b0, o0, e0;
  logic [9:0] q_n[$];
  logic [9:0] q_e[$];

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                  .PARITY(0), .FIFO_DEPTH(DEPTH), .IDLE_BITS(16)) dut_n (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_n), .rx_data(data_n), .rx_parity_err(perr_n),
    .rx_frame_err(ferr_n), .rx_valid(valid_n), .rx_ready(ready_n), .rx_break(brk_n),
    .rx_overrun(ovr_n), .rx_idle(idle_n), .rx_eop(eop_n), .fifo_count(cnt_n));

  uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                  .PARITY(2), .FIFO_DEPTH(DEPTH), .IDLE_BITS(16)) dut_e (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_e), .rx_data(data_e), .rx_parity_err(perr_e),
    .rx_frame_err(ferr_e), .rx_valid(valid_e), .rx_ready(ready_e), .rx_break(brk_e),
    .rx_overrun(ovr_e), .rx_idle(idle_e), .rx_eop(eop_e), .fifo_count(cnt_e));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pops and pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n && valid_n && ready_n) begin
      check("n_sb_nonempty", 32'(q_n.size() != 0), 32'd1);
      if (q_n.size() != 0) check("n_entry", {22'd0, perr_n, ferr_n, data_n}, {22'd0, q_n.pop_front()});
    end
    if (rst_n && valid_e && ready_e) begin
      check("e_sb_nonempty", 32'(q_e.size() != 0), 32'd1);
      if (q_e.size() != 0) check("e_entry", {22'd0, perr_e, ferr_e, data_e}, {22'd0, q_e.pop_front()});
    end
    if (brk_n) brk_cnt_n <= brk_cnt_n + 1;
    if (ovr_n) ovr_cnt_n <= ovr_cnt_n + 1;
    if (eop_n) eop_cnt_n <= eop_cnt_n + 1;
    if (brk_e) brk_cnt_e <= brk_cnt_e + 1;
  end

  task automatic drive(input bit to_e, input logic v);
    if (to_e) rxd_e = v;
    else      rxd_n = v;
  endtask

  task automatic send(input bit to_e, input logic [7:0] d, input bit has_par,
                      input logic pbit, input logic stop);
    drive(to_e, 1'b0);
    #(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(to_e, d[i]);
      #(BIT);
    end
    if (has_par) begin
      drive(to_e, pbit);
      #(BIT);
    end
    drive(to_e, stop);
    #(BIT);
    drive(to_e, 1'b1);
  endtask

  task automatic set_ready_n(input logic v);
    @(posedge clk);
    #1 ready_n = v;
  endtask

  initial begin
    rst_n = 1'b0; rxd_n = 1'b1; rxd_e = 1'b1; ready_n = 1'b0; ready_e = 1'b1;
    #53;
    check("rst_outs", 32'({valid_n, idle_n, brk_n, ovr_n, eop_n, perr_n, ferr_n}), 32'd0);
    check("rst_count", 32'(cnt_n), 32'd0);
    check("rst_data", 32'(data_n), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    #(20*BIT);
    check("idle_after_reset", 32'(idle_n), 32'd1);
    check("no_eop_without_char", 32'(eop_cnt_n), 32'd0);

    // 8N1 clean character held at the FIFO head
    q_n.push_back({2'b00, 8'h55});
    send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    #(BIT);
    check("8n1_valid", 32'(valid_n), 32'd1);
    check("8n1_data", 32'(data_n), 32'h55);
    check("8n1_flags", 32'({perr_n, ferr_n}), 32'd0);
    check("8n1_count", 32'(cnt_n), 32'd1);
    set_ready_n(1'b1);
    #40;
    check("8n1_count_popped", 32'(cnt_n), 32'd0);

    // Framing error, line held low afterwards, then a clean rearm
    b0 = brk_cnt_n;
    q_n.push_back({2'b01, 8'h0F});
    send(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0);
    #(2*BIT);
    drive(1'b0, 1'b1);
    #(BIT);
    q_n.push_back({2'b00, 8'h3C});
    send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    #(2*BIT);
    check("frame_no_break", 32'(brk_cnt_n - b0), 32'd0);

    // Break: 12 bit-times low
    b0 = brk_cnt_n;
    rxd_n = 1'b0;
    #(12*BIT);
    rxd_n = 1'b1;
    #(2*BIT);
    check("break_pulse", 32'(brk_cnt_n - b0), 32'd1);
    check("break_no_push", 32'(cnt_n), 32'd0);

    // Sub-tick glitch on an idle line
    #(18*BIT);
    check("glitch_pre_idle", 32'(idle_n), 32'd1);
    rxd_n = 1'b0;
    #30;
    rxd_n = 1'b1;
    #(2*BIT);
    check("glitch_idle_kept", 32'(idle_n), 32'd1);
    check("glitch_count", 32'(cnt_n), 32'd0);

    // Overrun: five characters into a four-entry FIFO
    set_ready_n(1'b0);
    o0 = ovr_cnt_n;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) q_n.push_back({2'b00, 8'(k)});
      send(1'b0, 8'(k), 1'b0, 1'b0, 1'b1);
    end
    #(BIT);
    check("ovr_count", 32'(cnt_n), 32'd4);
    check("ovr_pulses", 32'(ovr_cnt_n - o0), 32'd1);
    check("ovr_head", 32'(data_n), 32'h01);
    set_ready_n(1'b1);
    #100;
    check("ovr_drained", 32'(cnt_n), 32'd0);

    // Idle and end of packet after a burst of three
    #(20*BIT);
    e0 = eop_cnt_n;
    q_n.push_back({2'b00, 8'h12}); send(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    q_n.push_back({2'b00, 8'h34}); send(1'b0, 8'h34, 1'b0, 1'b0, 1'b1);
    q_n.push_back({2'b00, 8'h56}); send(1'b0, 8'h56, 1'b0, 1'b0, 1'b1);
    #(14*BIT + BIT/2);
    check("eop_not_yet_idle", 32'(idle_n), 32'd0);
    check("eop_not_yet", 32'(eop_cnt_n - e0), 32'd0);
    #(2*BIT);
    check("eop_idle", 32'(idle_n), 32'd1);
    check("eop_pulse", 32'(eop_cnt_n - e0), 32'd1);
    #(20*BIT);
    check("eop_single", 32'(eop_cnt_n - e0), 32'd1);

    // Even parity: bad parity bit, good parity bit, then a break
    q_e.push_back({2'b10, 8'hA3});
    send(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1);
    q_e.push_back({2'b00, 8'h07});
    send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    b0 = brk_cnt_e;
    rxd_e = 1'b0;
    #(12*BIT);
    rxd_e = 1'b1;
    #(2*BIT);
    check("e_break_pulse", 32'(brk_cnt_e - b0), 32'd1);
    check("e_count", 32'(cnt_e), 32'd0);

    // Reset in the middle of a frame with two entries queued
    set_ready_n(1'b0);
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    #(BIT);
    check("mid_rst_queued", 32'(cnt_n), 32'd2);
    rxd_n = 1'b0;
    #(BIT);
    rxd_n = 1'b1;
    #(3*BIT);
    rst_n = 1'b0;
    #40;
    check("mid_rst_count", 32'(cnt_n), 32'd0);
    check("mid_rst_valid", 32'(valid_n), 32'd0);
    #(BIT);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_ready_n(1'b1);
    q_n.push_back({2'b00, 8'h81});
    send(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    #(2*BIT);

    check("n_sb_drained", 32'(q_n.size()), 32'd0);
    check("e_sb_drained", 32'(q_e.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
